// File: rtl/ttc_trigger_sequencer.sv
// TTC Channel A trigger sequencer: numbers and time-stamps triggers, applies dead time and
// fill-type filtering, and queues records in a first-word fall-through FIFO.
module ttc_trigger_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int DEADTIME   = 4,
  parameter int NUM_WIDTH  = 24,
  parameter int TS_WIDTH   = 44
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 trigger,
  input  logic [2:0]           fill_type,
  input  logic                 accept_pulse_triggers,
  input  logic                 reset_trig_num,
  input  logic                 reset_trig_timestamp,
  input  logic                 rec_ready,
  output logic                 rec_valid,
  output logic [NUM_WIDTH-1:0] rec_num,
  output logic [TS_WIDTH-1:0]  rec_timestamp,
  output logic [2:0]           rec_fill_type,
  output logic                 busy,
  output logic [15:0]          dead_drop_count,
  output logic [31:0]          overflow_count,
  input  logic [31:0]          thres_overflow,
  output logic                 error_overflow
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((DEADTIME > 0) ? DEADTIME - 1 : 0);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, DEAD} state_t;
  typedef struct packed {
    logic [NUM_WIDTH-1:0] num;
    logic [TS_WIDTH-1:0]  ts;
    logic [2:0]           ft;
  } rec_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [NUM_WIDTH-1:0] tn_q, tn_d;
  logic [15:0]          dead_drop_q, dead_drop_d;
  logic [31:0]          overflow_q, overflow_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  rec_t                 mem_q [FIFO_DEPTH];
  rec_t                 new_rec, head;
  logic                 fill_ok, idle, full, accept, drop_dead, drop_ovf, push, pop;

  always_comb begin
    fill_ok   = (fill_type == 3'b001) || (fill_type == 3'b010) || (fill_type == 3'b011) ||
                (fill_type == 3'b100 && accept_pulse_triggers);
    idle      = (state_q == IDLE);
    // full is taken from the registered occupancy, i.e. before this cycle's pop
    full      = (count_q == FULL_CNT);
    accept    = trigger && idle && fill_ok && !full;
    drop_dead = trigger && !(idle && fill_ok);
    drop_ovf  = trigger && idle && fill_ok && full;
    rec_valid = (count_q != '0);
    pop       = rec_valid && rec_ready;
    push      = accept;

    new_rec.num = reset_trig_num ? NUM_WIDTH'(1) : tn_q + NUM_WIDTH'(1);
    new_rec.ts  = reset_trig_timestamp ? '0 : ts_q;
    new_rec.ft  = fill_type;

    ts_d = reset_trig_timestamp ? '0 : ts_q + TS_WIDTH'(1);
    tn_d = tn_q;
    if (accept)              tn_d = new_rec.num;
    else if (reset_trig_num) tn_d = '0;

    dead_drop_d = (drop_dead && dead_drop_q != '1) ? dead_drop_q + 16'd1 : dead_drop_q;
    overflow_d  = (drop_ovf && overflow_q != '1) ? overflow_q + 32'd1 : overflow_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept && DEADTIME > 0) begin
        state_d = DEAD;
        cnt_d   = CNT_INIT;
      end
      DEAD: if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ts_q        <= '0;
      tn_q        <= '0;
      dead_drop_q <= '0;
      overflow_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ts_q        <= ts_d;
      tn_q        <= tn_d;
      dead_drop_q <= dead_drop_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_rec;
  end

  // Storage is not reset, so the head is masked to keep rec_* at zero when empty
  always_comb begin
    head           = rec_valid ? mem_q[rd_ptr_q] : '0;
    rec_num        = head.num;
    rec_timestamp  = head.ts;
    rec_fill_type  = head.ft;
    busy           = (state_q == DEAD);
    dead_drop_count = dead_drop_q;
    overflow_count  = overflow_q;
    error_overflow  = (overflow_q > thres_overflow);
  end
endmodule

// File: tb/tb_ttc_trigger_sequencer.sv
// Directed bench for ttc_trigger_sequencer; cycle 0 is the first cycle after reset release.
module tb_ttc_trigger_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        trigger, accept_pulse_triggers, reset_trig_num, reset_trig_timestamp, rec_ready;
  logic [2:0]  fill_type;
  logic        rec_valid, busy, error_overflow;
  logic [23:0] rec_num;
  logic [43:0] rec_timestamp;
  logic [2:0]  rec_fill_type;
  logic [15:0] dead_drop_count;
  logic [31:0] overflow_count, thres_overflow;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  ttc_trigger_sequencer #(.FIFO_DEPTH(16), .DEADTIME(4), .NUM_WIDTH(24), .TS_WIDTH(44)) dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .fill_type(fill_type),
    .accept_pulse_triggers(accept_pulse_triggers), .reset_trig_num(reset_trig_num),
    .reset_trig_timestamp(reset_trig_timestamp), .rec_ready(rec_ready), .rec_valid(rec_valid),
    .rec_num(rec_num), .rec_timestamp(rec_timestamp), .rec_fill_type(rec_fill_type),
    .busy(busy), .dead_drop_count(dead_drop_count), .overflow_count(overflow_count),
    .thres_overflow(thres_overflow), .error_overflow(error_overflow));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1; tick(); trigger = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; trigger = 1'b0; fill_type = 3'b001; accept_pulse_triggers = 1'b0;
    reset_trig_num = 1'b0; reset_trig_timestamp = 1'b0; rec_ready = 1'b1; thres_overflow = '0;
    #3; @(posedge clk); #1; reset_n = 1'b1; cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0; #2;
    tests_run++; if ({rec_valid, busy, error_overflow} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {rec_valid, busy, error_overflow}); end
    tests_run++; if ({rec_num, rec_timestamp, rec_fill_type} !== '0) begin tests_failed++; $display("FAIL reset_rec: got num %0d ts %0d ft %0d want 0", rec_num, rec_timestamp, rec_fill_type); end
    tests_run++; if (dead_drop_count !== 16'd0 || overflow_count !== 32'd0) begin tests_failed++; $display("FAIL reset_counts: got %0d/%0d want 0/0", dead_drop_count, overflow_count); end
    @(posedge clk); #1; reset_n = 1'b1; cyc = 0;
  endtask

  task automatic test_basic();
    do_reset();
    goto_cycle(10);
    tests_run++; if (rec_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_empty: got %b want 0", rec_valid); end
    pulse_trigger();
    tests_run++; if ({rec_valid, rec_num, rec_timestamp, rec_fill_type} !== {1'b1, 24'd1, 44'd10, 3'b001}) begin tests_failed++; $display("FAIL basic_rec1: got v%b num %0d ts %0d ft %0d want v1 num 1 ts 10 ft 1", rec_valid, rec_num, rec_timestamp, rec_fill_type); end
    tick();
    tests_run++; if (rec_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_popped: got %b want 0", rec_valid); end
    goto_cycle(20);
    pulse_trigger();
    tests_run++; if ({rec_valid, rec_num, rec_timestamp} !== {1'b1, 24'd2, 44'd20}) begin tests_failed++; $display("FAIL basic_rec2: got v%b num %0d ts %0d want v1 num 2 ts 20", rec_valid, rec_num, rec_timestamp); end
  endtask

  task automatic test_deadtime();
    do_reset();
    goto_cycle(10);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL dead_busy_pre: got %b want 0", busy); end
    pulse_trigger();
    for (int c = 11; c <= 14; c++) begin
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL dead_busy_c%0d: got %b want 1", c, busy); end
      if (c == 12) pulse_trigger(); else tick();
    end
    tests_run++; if (busy !== 1'b0 || rec_valid !== 1'b0) begin tests_failed++; $display("FAIL dead_idle15: got busy %b valid %b want 0 0", busy, rec_valid); end
    pulse_trigger();
    tests_run++; if ({rec_valid, rec_num, rec_timestamp} !== {1'b1, 24'd2, 44'd15}) begin tests_failed++; $display("FAIL dead_rec2: got v%b num %0d ts %0d want v1 num 2 ts 15", rec_valid, rec_num, rec_timestamp); end
    tests_run++; if (dead_drop_count !== 16'd1) begin tests_failed++; $display("FAIL dead_drop: got %0d want 1", dead_drop_count); end
  endtask

  task automatic test_fill_filter();
    do_reset();
    fill_type = 3'b100; accept_pulse_triggers = 1'b0;
    goto_cycle(2);
    pulse_trigger();
    tests_run++; if (rec_valid !== 1'b0 || busy !== 1'b0 || dead_drop_count !== 16'd1) begin tests_failed++; $display("FAIL fill_gated: got v%b busy %b drops %0d want v0 busy 0 drops 1", rec_valid, busy, dead_drop_count); end
    accept_pulse_triggers = 1'b1;
    pulse_trigger();
    tests_run++; if ({rec_valid, rec_num, rec_fill_type} !== {1'b1, 24'd1, 3'b100}) begin tests_failed++; $display("FAIL fill_async: got v%b num %0d ft %0d want v1 num 1 ft 4", rec_valid, rec_num, rec_fill_type); end
    fill_type = 3'b000; repeat (6) tick();
    pulse_trigger();
    tests_run++; if (dead_drop_count !== 16'd2) begin tests_failed++; $display("FAIL fill_bad_code: got %0d want 2", dead_drop_count); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    rec_ready = 1'b0; thres_overflow = 32'd2;
    goto_cycle(2);
    for (int i = 0; i < 19; i++) begin
      if (i == 18) begin
        tests_run++; if (overflow_count !== 32'd2 || error_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_at_thres: got cnt %0d err %b want 2 0", overflow_count, error_overflow); end
      end
      pulse_trigger();
      repeat (5) tick();
    end
    tests_run++; if (overflow_count !== 32'd3 || error_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_count: got cnt %0d err %b want 3 1", overflow_count, error_overflow); end
    tests_run++; if (dead_drop_count !== 16'd0) begin tests_failed++; $display("FAIL ovf_no_dead: got %0d want 0", dead_drop_count); end
    tests_run++; if ({rec_valid, rec_num, rec_timestamp} !== {1'b1, 24'd1, 44'd2}) begin tests_failed++; $display("FAIL ovf_head_hold: got v%b num %0d ts %0d want v1 num 1 ts 2", rec_valid, rec_num, rec_timestamp); end
    rec_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      ok = (rec_valid === 1'b1) && (rec_num === 24'(i)) && (rec_timestamp === 44'(2 + 6 * (i - 1)));
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL ovf_drain_%0d: got v%b num %0d ts %0d want v1 num %0d ts %0d", i, rec_valid, rec_num, rec_timestamp, i, 2 + 6 * (i - 1)); end
      tick();
    end
    tests_run++; if (rec_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_drained: got %b want 0", rec_valid); end
  endtask

  task automatic test_reset_strobes();
    do_reset();
    goto_cycle(2);
    for (int i = 1; i <= 5; i++) begin
      pulse_trigger();
      repeat (5) tick();
    end
    tests_run++; if (rec_valid !== 1'b0) begin tests_failed++; $display("FAIL strobe_pre_empty: got %b want 0", rec_valid); end
    trigger = 1'b1; reset_trig_num = 1'b1; reset_trig_timestamp = 1'b1;
    tick();
    trigger = 1'b0; reset_trig_num = 1'b0; reset_trig_timestamp = 1'b0;
    tests_run++; if ({rec_valid, rec_num, rec_timestamp} !== {1'b1, 24'd1, 44'd0}) begin tests_failed++; $display("FAIL strobe_rec1: got v%b num %0d ts %0d want v1 num 1 ts 0", rec_valid, rec_num, rec_timestamp); end
    repeat (5) tick();
    pulse_trigger();
    tests_run++; if ({rec_valid, rec_num, rec_timestamp} !== {1'b1, 24'd2, 44'd5}) begin tests_failed++; $display("FAIL strobe_rec2: got v%b num %0d ts %0d want v1 num 2 ts 5", rec_valid, rec_num, rec_timestamp); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    rec_ready = 1'b0;
    goto_cycle(2);
    for (int i = 0; i < 3; i++) begin
      pulse_trigger();
      if (i < 2) repeat (5) tick();
    end
    pulse_trigger();
    tests_run++; if ({rec_valid, busy} !== 2'b11 || dead_drop_count !== 16'd1) begin tests_failed++; $display("FAIL mid_pre: got v%b busy %b drops %0d want v1 busy 1 drops 1", rec_valid, busy, dead_drop_count); end
    #2; reset_n = 1'b0; #1;
    tests_run++; if ({rec_valid, busy} !== 2'b00 || dead_drop_count !== 16'd0 || rec_num !== 24'd0) begin tests_failed++; $display("FAIL mid_async: got v%b busy %b drops %0d num %0d want all 0", rec_valid, busy, dead_drop_count, rec_num); end
    @(posedge clk); #1; reset_n = 1'b1; cyc = 0;
    rec_ready = 1'b1;
    goto_cycle(3);
    pulse_trigger();
    tests_run++; if ({rec_valid, rec_num, rec_timestamp} !== {1'b1, 24'd1, 44'd3}) begin tests_failed++; $display("FAIL mid_after: got v%b num %0d ts %0d want v1 num 1 ts 3", rec_valid, rec_num, rec_timestamp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_deadtime();
    test_fill_filter();
    test_overflow();
    test_reset_strobes();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
